// File: rtl/atm_pkg.sv
// atm_pkg: shared definitions for the ATM protocol monitor.
//   - mon_state_e      : monitor FSM states
//   - ERR_*            : error codes reported on err_code (0 = no error)
//   - ST_*             : control-unit state encodings observed on the DUT
//   - lowest_err_code  : lowest active code of a detection vector
package atm_pkg;

    typedef enum logic [2:0] {
        M_IDLE      = 3'd0,
        M_ENTRY     = 3'd1,
        M_SESSION   = 3'd2,
        M_WAIT_UPD  = 3'd3,
        M_WAIT_LOCK = 3'd4
    } mon_state_e;

    localparam int NUM_CHECKS = 5;

    localparam logic [2:0] ERR_NONE           = 3'd0;
    localparam logic [2:0] ERR_CARD_ENTRY     = 3'd1;
    localparam logic [2:0] ERR_OVERDRAW       = 3'd2;
    localparam logic [2:0] ERR_UPDATE_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_UPDATE_VALUE   = 3'd4;
    localparam logic [2:0] ERR_LOCK_TIMEOUT   = 3'd5;

    localparam int ST_IDLE     = 0;
    localparam int ST_PIN      = 1;
    localparam int ST_CHECK    = 2;
    localparam int ST_WITHDRAW = 5;
    localparam int ST_DEPOSIT  = 7;

    // Bit i of det stands for error code i+1; the lowest code wins.
    function automatic logic [2:0] lowest_err_code(input logic [NUM_CHECKS-1:0] det);
        logic [2:0] code;
        code = ERR_NONE;
        for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
            if (det[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/atm_err_logger.sv
// atm_err_logger: registers and accumulates enabled error detections.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   det_i[4:0]          enabled detections this cycle (bit i = code i+1)
//   acc_i               account number of the current session
//   err_valid_o/code_o  one-cycle pulse with the lowest detected code
//   err_sticky_o        OR of all detections since reset
//   err_count_o         saturating count of error cycles
//   first_err_code_o/acc_o  code and account of the first error since reset
module atm_err_logger
    import atm_pkg::*;
#(
    parameter int ACC_W         = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CHECKS-1:0]    det_i,
    input  logic [ACC_W-1:0]         acc_i,
    output logic                     err_valid_o,
    output logic [2:0]               err_code_o,
    output logic [NUM_CHECKS-1:0]    err_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0] err_count_o,
    output logic [2:0]               first_err_code_o,
    output logic [ACC_W-1:0]         first_err_acc_o
);

    logic                     any_err;
    logic                     err_valid_q;
    logic [2:0]               err_code_q;
    logic [NUM_CHECKS-1:0]    sticky_q;
    logic [ERR_CNT_WIDTH-1:0] count_q;
    logic [2:0]               first_code_q;
    logic [ACC_W-1:0]         first_acc_q;

    assign any_err = |det_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_q  <= 1'b0;
            err_code_q   <= ERR_NONE;
            count_q      <= '0;
            first_code_q <= ERR_NONE;
            first_acc_q  <= '0;
        end else begin
            err_valid_q <= any_err;
            // lowest_err_code returns 0 for an empty vector, so the code
            // reads 0 whenever the pulse is low.
            err_code_q  <= lowest_err_code(det_i);
            // Simultaneous errors count as one event.
            if (any_err && (count_q != '1)) count_q <= count_q + 1'b1;
            if (any_err && (first_code_q == ERR_NONE)) begin
                first_code_q <= lowest_err_code(det_i);
                first_acc_q  <= acc_i;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_sticky
        always_ff @(posedge clk or posedge rst) begin
            if (rst)            sticky_q[gi] <= 1'b0;
            else if (det_i[gi]) sticky_q[gi] <= 1'b1;
        end
    end

    assign err_valid_o      = err_valid_q;
    assign err_code_o       = err_code_q;
    assign err_sticky_o     = sticky_q;
    assign err_count_o      = count_q;
    assign first_err_code_o = first_code_q;
    assign first_err_acc_o  = first_acc_q;

endmodule

// File: rtl/atm_protocol_monitor.sv
// atm_protocol_monitor: passive checker of an ATM control unit's protocol.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   chk_en[4:0]               per-check enable (bit i enables code i+1)
//   CardInserted, Acc_Number  card presence level, session account
//   ControlUnit_CurrentState  observed control-unit state
//   pin_try_valid, pin_match  PIN comparison strobe and result
//   acc_deact_wr              account deactivation write strobe
//   bal_wr_valid, bal_wr_data balance write strobe and value
//   Cash_Amount, RAM_OutReadBalance  operation amount, current balance
//   err_*                     error pulse, code, sticky bits, count, first error
module atm_protocol_monitor
    import atm_pkg::*;
#(
    parameter int NUM_OF_STATES  = 11,
    parameter int NUM_OF_TRIES   = 5,
    parameter int SAVED_ACCOUNTS = 10,
    parameter int BALANCE_WIDTH  = 16,
    parameter int UPDATE_TIMEOUT = 3,
    parameter int LOCK_TIMEOUT   = 3,
    parameter int ERR_CNT_WIDTH  = 8,
    localparam int ACC_W = $clog2(SAVED_ACCOUNTS),
    localparam int ST_W  = $clog2(NUM_OF_STATES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               chk_en,
    input  logic                     CardInserted,
    input  logic [ACC_W-1:0]         Acc_Number,
    input  logic [ST_W-1:0]          ControlUnit_CurrentState,
    input  logic                     pin_try_valid,
    input  logic                     pin_match,
    input  logic                     acc_deact_wr,
    input  logic                     bal_wr_valid,
    input  logic [BALANCE_WIDTH-1:0] bal_wr_data,
    input  logic [BALANCE_WIDTH-1:0] Cash_Amount,
    input  logic [BALANCE_WIDTH-1:0] RAM_OutReadBalance,
    output logic                     err_valid,
    output logic [2:0]               err_code,
    output logic [4:0]               err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [2:0]               first_err_code,
    output logic [ACC_W-1:0]         first_err_acc
);

    localparam int FAIL_W  = $clog2(NUM_OF_TRIES + 1);
    localparam int TMR_MAX = (UPDATE_TIMEOUT > LOCK_TIMEOUT) ? UPDATE_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    mon_state_e               state_q, state_d;
    logic                     card_q;
    logic [FAIL_W-1:0]        fail_q, fail_d, fail_inc;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic [BALANCE_WIDTH-1:0] expect_q, expect_d;
    logic [NUM_CHECKS-1:0]    det, det_en;
    logic                     card_rise, card_fall, lock_hit, overdraw;

    assign card_rise = CardInserted & ~card_q;
    assign card_fall = ~CardInserted & card_q;
    assign overdraw  = (ControlUnit_CurrentState == ST_W'(ST_WITHDRAW)) &&
                       (Cash_Amount > RAM_OutReadBalance);
    // Saturate so repeated failures after a lock timeout cannot wrap.
    assign fail_inc  = (fail_q == FAIL_W'(NUM_OF_TRIES)) ? fail_q : fail_q + FAIL_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= M_IDLE;
            card_q   <= 1'b0;
            fail_q   <= '0;
            timer_q  <= '0;
            expect_q <= '0;
        end else begin
            state_q  <= state_d;
            card_q   <= CardInserted;
            fail_q   <= fail_d;
            timer_q  <= timer_d;
            expect_q <= expect_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        expect_d = expect_q;
        det      = '0;
        lock_hit = 1'b0;
        // Card edges override everything else and never raise an error.
        if (card_fall) begin
            state_d = M_IDLE;
        end else if (card_rise) begin
            state_d = M_ENTRY;
            fail_d  = '0;
        end else begin
            unique case (state_q)
                M_IDLE: ;
                M_ENTRY: begin
                    if (ControlUnit_CurrentState != ST_W'(ST_PIN)) det[0] = 1'b1;
                    state_d = M_SESSION;
                end
                M_SESSION: begin
                    if (pin_try_valid && !pin_match) begin
                        fail_d = fail_inc;
                        if (fail_inc == FAIL_W'(NUM_OF_TRIES)) begin
                            lock_hit = 1'b1;
                            state_d  = M_WAIT_LOCK;
                            timer_d  = '0;
                        end
                    end else if (pin_try_valid && pin_match) begin
                        fail_d = '0;
                    end
                    if (!lock_hit) begin
                        if (ControlUnit_CurrentState == ST_W'(ST_WITHDRAW)) begin
                            if (overdraw) begin
                                det[1] = 1'b1;
                            end else begin
                                expect_d = RAM_OutReadBalance - Cash_Amount;
                                state_d  = M_WAIT_UPD;
                                timer_d  = '0;
                            end
                        end else if (ControlUnit_CurrentState == ST_W'(ST_DEPOSIT)) begin
                            // Deposit wraps modulo 2^BALANCE_WIDTH by truncation.
                            expect_d = RAM_OutReadBalance + Cash_Amount;
                            state_d  = M_WAIT_UPD;
                            timer_d  = '0;
                        end
                    end
                end
                M_WAIT_UPD: begin
                    if (bal_wr_valid) begin
                        if (bal_wr_data != expect_q) det[3] = 1'b1;
                        state_d = M_SESSION;
                    end else if (timer_q == TMR_W'(UPDATE_TIMEOUT - 1)) begin
                        det[2]  = 1'b1;
                        state_d = M_SESSION;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                M_WAIT_LOCK: begin
                    // The overdraw check holds no pending expectation, so it
                    // stays armed while waiting for the lockout write.
                    if (overdraw) det[1] = 1'b1;
                    if (acc_deact_wr) begin
                        fail_d  = '0;
                        state_d = M_SESSION;
                    end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                        det[4]  = 1'b1;
                        state_d = M_SESSION;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                default: state_d = M_IDLE;
            endcase
        end
    end

    assign det_en = det & chk_en;

    atm_err_logger #(
        .ACC_W         (ACC_W),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_logger (
        .clk              (clk),
        .rst              (rst),
        .det_i            (det_en),
        .acc_i            (Acc_Number),
        .err_valid_o      (err_valid),
        .err_code_o       (err_code),
        .err_sticky_o     (err_sticky),
        .err_count_o      (err_count),
        .first_err_code_o (first_err_code),
        .first_err_acc_o  (first_err_acc)
    );

endmodule

// File: tb/tb_atm_protocol_monitor.sv
// Bench for atm_protocol_monitor: directed scenarios plus randomized
// withdraw/deposit transactions; expected outputs come from a small
// error-log model fed with the codes each scenario must raise.
module tb_atm_protocol_monitor;

    localparam int ACC_W = 4;
    localparam int ST_W  = 4;
    localparam int BW    = 16;
    localparam int CW    = 8;

    localparam logic [ST_W-1:0] S_PIN   = 4'd1;
    localparam logic [ST_W-1:0] S_CHECK = 4'd2;
    localparam logic [ST_W-1:0] S_WD    = 4'd5;
    localparam logic [ST_W-1:0] S_DEP   = 4'd7;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      chk_en;
    logic            CardInserted;
    logic [ACC_W-1:0] Acc_Number;
    logic [ST_W-1:0] ControlUnit_CurrentState;
    logic            pin_try_valid, pin_match, acc_deact_wr, bal_wr_valid;
    logic [BW-1:0]   bal_wr_data, Cash_Amount, RAM_OutReadBalance;
    logic            err_valid;
    logic [2:0]      err_code, first_err_code;
    logic [4:0]      err_sticky;
    logic [CW-1:0]   err_count;
    logic [ACC_W-1:0] first_err_acc;

    int total = 0;
    int bad   = 0;

    // Error-log model state
    logic            m_valid;
    logic [2:0]      m_code, m_first_code;
    logic [4:0]      m_sticky;
    int              m_count;
    logic [ACC_W-1:0] m_first_acc;

    always #5 clk = ~clk;

    atm_protocol_monitor dut (
        .clk                      (clk),
        .rst                      (rst),
        .chk_en                   (chk_en),
        .CardInserted             (CardInserted),
        .Acc_Number               (Acc_Number),
        .ControlUnit_CurrentState (ControlUnit_CurrentState),
        .pin_try_valid            (pin_try_valid),
        .pin_match                (pin_match),
        .acc_deact_wr             (acc_deact_wr),
        .bal_wr_valid             (bal_wr_valid),
        .bal_wr_data              (bal_wr_data),
        .Cash_Amount              (Cash_Amount),
        .RAM_OutReadBalance       (RAM_OutReadBalance),
        .err_valid                (err_valid),
        .err_code                 (err_code),
        .err_sticky               (err_sticky),
        .err_count                (err_count),
        .first_err_code           (first_err_code),
        .first_err_acc            (first_err_acc)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},  32'(err_valid),      32'(m_valid));
        check({tag, ".code"},   32'(err_code),       32'(m_code));
        check({tag, ".sticky"}, 32'(err_sticky),     32'(m_sticky));
        check({tag, ".count"},  32'(err_count),      32'(m_count));
        check({tag, ".fcode"},  32'(first_err_code), 32'(m_first_code));
        check({tag, ".facc"},   32'(first_err_acc),  32'(m_first_acc));
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_code = 3'd0; m_sticky = 5'd0; m_count = 0;
        m_first_code = 3'd0; m_first_acc = '0;
    endtask

    // raised: codes the scenario rules say are detected in the current cycle
    // (bit c-1 = code c). Advances one clock and checks the registered result.
    task automatic tick_chk(input string tag, input logic [4:0] raised);
        logic [4:0] m;
        m = raised & chk_en;
        m_valid = |m;
        m_code  = 3'd0;
        if (|m) begin
            for (int c = 1; c <= 5; c++)
                if (m[c-1] && m_code == 3'd0) m_code = 3'(c);
            m_sticky = m_sticky | m;
            if (m_count < 255) m_count++;
            if (m_first_code == 3'd0) begin
                m_first_code = m_code;
                m_first_acc  = Acc_Number;
            end
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic quiet_inputs();
        pin_try_valid = 1'b0; pin_match = 1'b0; acc_deact_wr = 1'b0;
        bal_wr_valid = 1'b0; bal_wr_data = '0;
        ControlUnit_CurrentState = S_CHECK;
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        CardInserted = 1'b0;
        quiet_inputs();
        model_reset();
        #1;
        check_all(tag);       // asynchronous: cleared before any clock edge
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic insert_card(input string tag, input logic [ST_W-1:0] st);
        CardInserted = 1'b1;
        tick_chk({tag, ".rise"}, 5'b0);
        ControlUnit_CurrentState = st;
        tick_chk({tag, ".entry"}, (st != S_PIN) ? 5'b00001 : 5'b00000);
        ControlUnit_CurrentState = S_CHECK;
    endtask

    task automatic remove_card();
        CardInserted = 1'b0;
        tick_chk("fall", 5'b0);
    endtask

    task automatic fail_tries(input int n);
        pin_try_valid = 1'b1; pin_match = 1'b0;
        repeat (n) tick_chk("pin_fail", 5'b0);
        pin_try_valid = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] bal, cash, expb;
        int wd, resp, dly;

        rst = 1'b1; chk_en = 5'b11111; Acc_Number = '0;
        Cash_Amount = '0; RAM_OutReadBalance = '0;
        apply_reset("reset");

        // Card entry checks
        Acc_Number = ACC_W'($urandom_range(0, 9));
        insert_card("entry_ok", S_PIN);
        remove_card();
        insert_card("entry_bad", 4'd0);
        check("entry_bad.count1", 32'(err_count), 32'd1);

        // PIN lockout: random partial failures, a match, then five failures
        fail_tries($urandom_range(0, 4));
        pin_try_valid = 1'b1; pin_match = 1'b1;
        tick_chk("pin_match", 5'b0);
        fail_tries(5);
        tick_chk("lock_wait", 5'b0);
        acc_deact_wr = 1'b1;
        tick_chk("lock_deact", 5'b0);
        acc_deact_wr = 1'b0;
        fail_tries(5);
        tick_chk("lock_w0", 5'b0);
        tick_chk("lock_w1", 5'b0);
        tick_chk("lock_to", 5'b10000);
        remove_card();
        insert_card("s3", S_PIN);

        // Directed withdraw / deposit
        RAM_OutReadBalance = 16'd200; Cash_Amount = 16'd300;
        ControlUnit_CurrentState = S_WD;  tick_chk("overdraw", 5'b00010);
        Cash_Amount = 16'd150;
        ControlUnit_CurrentState = S_WD;  tick_chk("wd_op", 5'b0);
        ControlUnit_CurrentState = S_CHECK;
        bal_wr_valid = 1'b1; bal_wr_data = 16'd50;
        tick_chk("wd_wr_ok", 5'b0);
        bal_wr_valid = 1'b0;
        ControlUnit_CurrentState = S_WD;  tick_chk("wd_op2", 5'b0);
        ControlUnit_CurrentState = S_CHECK;
        bal_wr_valid = 1'b1; bal_wr_data = 16'd60;
        tick_chk("wd_wr_bad", 5'b01000);
        bal_wr_valid = 1'b0;
        RAM_OutReadBalance = 16'hFFFA; Cash_Amount = 16'd10;
        ControlUnit_CurrentState = S_DEP; tick_chk("dep_op", 5'b0);
        ControlUnit_CurrentState = S_CHECK;
        bal_wr_valid = 1'b1; bal_wr_data = 16'h0004;
        tick_chk("dep_wrap", 5'b0);
        bal_wr_valid = 1'b0;
        ControlUnit_CurrentState = S_DEP; tick_chk("dep_op2", 5'b0);
        ControlUnit_CurrentState = S_CHECK;
        tick_chk("dep_w0", 5'b0);
        tick_chk("dep_w1", 5'b0);
        tick_chk("dep_to", 5'b00100);

        // Randomized transactions with random enables and accounts
        for (int t = 0; t < 24; t++) begin
            bal  = BW'($urandom);
            cash = BW'($urandom);
            wd   = $urandom_range(0, 1);
            resp = $urandom_range(0, 2);
            dly  = $urandom_range(0, 2);
            chk_en = 5'($urandom);
            Acc_Number = ACC_W'($urandom_range(0, 9));
            RAM_OutReadBalance = bal; Cash_Amount = cash;
            ControlUnit_CurrentState = (wd != 0) ? S_WD : S_DEP;
            $display("txn %0d: %s bal=%0d cash=%0d resp=%0d dly=%0d en=%b",
                     t, (wd != 0) ? "withdraw" : "deposit", bal, cash, resp, dly, chk_en);
            if (wd != 0 && cash > bal) begin
                tick_chk("rnd_ovd", 5'b00010);
                ControlUnit_CurrentState = S_CHECK;
            end else begin
                expb = (wd != 0) ? bal - cash : bal + cash;
                tick_chk("rnd_op", 5'b0);
                ControlUnit_CurrentState = S_CHECK;
                if (resp == 2) begin
                    repeat (2) tick_chk("rnd_wait", 5'b0);
                    tick_chk("rnd_to", 5'b00100);
                end else begin
                    repeat (dly) tick_chk("rnd_wait", 5'b0);
                    bal_wr_valid = 1'b1;
                    bal_wr_data  = (resp == 0) ? expb : expb ^ BW'($urandom_range(1, 65535));
                    tick_chk("rnd_wr", (resp == 0) ? 5'b00000 : 5'b01000);
                    bal_wr_valid = 1'b0;
                end
            end
        end
        chk_en = 5'b11111;

        // Simultaneous overdraw and lock timeout
        apply_reset("reset2");
        insert_card("combo", S_PIN);
        fail_tries(5);
        tick_chk("combo_w0", 5'b0);
        tick_chk("combo_w1", 5'b0);
        RAM_OutReadBalance = 16'd200; Cash_Amount = 16'd300;
        ControlUnit_CurrentState = S_WD;
        tick_chk("combo", 5'b10010);
        ControlUnit_CurrentState = S_CHECK;
        check("combo.sticky_lit", 32'(err_sticky), 32'h12);
        chk_en = 5'b11101;
        remove_card();
        insert_card("combo_m", S_PIN);
        fail_tries(5);
        tick_chk("combo_m_w0", 5'b0);
        tick_chk("combo_m_w1", 5'b0);
        ControlUnit_CurrentState = S_WD;
        tick_chk("combo_masked", 5'b10010);
        ControlUnit_CurrentState = S_CHECK;
        check("combo_masked.code5", 32'(err_code), 32'd5);
        chk_en = 5'b11111;

        // Counter saturation via persistent overdraw
        ControlUnit_CurrentState = S_WD;
        repeat (300) tick_chk("sat", 5'b00010);
        ControlUnit_CurrentState = S_CHECK;
        check("sat.count255", 32'(err_count), 32'd255);

        // Reset in the middle of a pending balance update
        Cash_Amount = 16'd150;
        ControlUnit_CurrentState = S_WD; tick_chk("rst_op", 5'b0);
        ControlUnit_CurrentState = S_CHECK;
        apply_reset("reset_mid");
        repeat (4) tick_chk("post_rst", 5'b0);
        bal_wr_valid = 1'b1; bal_wr_data = 16'd60;
        tick_chk("post_rst_wr", 5'b0);
        bal_wr_valid = 1'b0;
        insert_card("post_rst_card", S_PIN);
        repeat (4) tick_chk("post_rst_sess", 5'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
